// File: rtl/ysyx_22041071_wb_regfile_if.sv
// rtl/ysyx_22041071_wb_regfile_if.sv - writeback-to-regfile handshake bundle
interface ysyx_22041071_wb_regfile_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int INS_W  = 32
);
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_pc;
    logic [INS_W-1:0]  wb_ins;
    logic              wb_we;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output wb_valid, wb_pc, wb_ins, wb_we, wb_rd, wb_data,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_pc, wb_ins, wb_we, wb_rd, wb_data,
        output wb_ready
    );
endinterface

// File: rtl/ysyx_22041071_wb_regfile.sv
// rtl/ysyx_22041071_wb_regfile.sv - writeback receiver, 32x64 regfile, commit record; YSYX_22041071_RF_BYPASS_EN enables write-to-read forwarding
module ysyx_22041071_wb_regfile #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int INS_W  = 32,
    parameter int NREG   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    ysyx_22041071_wb_regfile_if.slave wb,
    input  logic [4:0]           rs1_addr,
    output logic [DATA_W-1:0]    rs1_data,
    input  logic [4:0]           rs2_addr,
    output logic [DATA_W-1:0]    rs2_data,
    output logic                 commit_valid,
    output logic [ADDR_W-1:0]    commit_pc,
    output logic [INS_W-1:0]     commit_ins,
    output logic [4:0]           commit_rd,
    output logic [DATA_W-1:0]    commit_data,
    output logic [63:0]          retire_cnt
);

    logic [DATA_W-1:0] regs [0:NREG-1];
    logic              ready_q;
    logic              accept;
    logic              do_write;

    assign wb.wb_ready = ready_q;
    assign accept      = wb.wb_valid & ready_q;
    assign do_write    = accept & wb.wb_we & (wb.wb_rd != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // x0 is never written, so the array entry stays at its reset value of 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (do_write) begin
            regs[wb.wb_rd] <= wb.wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            commit_ins   <= '0;
            commit_rd    <= '0;
            commit_data  <= '0;
            retire_cnt   <= '0;
        end else begin
            commit_valid <= accept;
            if (accept) begin
                commit_pc   <= wb.wb_pc;
                commit_ins  <= wb.wb_ins;
                commit_rd   <= do_write ? wb.wb_rd : 5'd0;
                commit_data <= do_write ? wb.wb_data : '0;
                retire_cnt  <= retire_cnt + 64'd1;
            end
        end
    end

    always_comb begin
        rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
        rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
`ifdef YSYX_22041071_RF_BYPASS_EN
        if (do_write && (rs1_addr == wb.wb_rd)) begin
            rs1_data = wb.wb_data;
        end
        if (do_write && (rs2_addr == wb.wb_rd)) begin
            rs2_data = wb.wb_data;
        end
`else
`endif
    end

endmodule

// File: doc/ysyx_22041071_wb_regfile.md
Name: ysyx_22041071_wb_regfile

Overview:
- Write-side receiver for the writeback stage's output handshake (valid7/PC7/Ins6/reg_w_en5/rdest4/WB_data2).
- Accepts one retiring instruction per cycle and updates the 32x64 integer register file.
- Registers a commit record (PC, instruction, rd, data) for the difftest harness and keeps a retire counter.
- Provides two combinational read ports to decode.

Parameters:
- DATA_W, 64, register and writeback data width.
- ADDR_W, 64, PC width.
- INS_W, 32, instruction width.
- NREG, 32, number of architectural registers; fixed at 32, since rd and rs addresses are 5 bits.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_valid  in  1  writeback beat valid; driven from WB valid7.
- wb_ready  out  1  accept signal back to WB; drives its ready.
- wb_pc  in  ADDR_W  PC of the retiring instruction.
- wb_ins  in  INS_W  instruction word of the retiring instruction.
- wb_we  in  1  register write enable.
- wb_rd  in  5  destination register index.
- wb_data  in  DATA_W  writeback data.
- rs1_addr  in  5  read port 1 index.
- rs1_data  out  DATA_W  read port 1 data.
- rs2_addr  in  5  read port 2 index.
- rs2_data  out  DATA_W  read port 2 data.
- commit_valid  out  1  one-cycle pulse, one cycle after each accepted beat.
- commit_pc  out  ADDR_W  registered PC of the last accepted beat.
- commit_ins  out  INS_W  registered instruction of the last accepted beat.
- commit_rd  out  5  registered rd; 0 if no write occurred.
- commit_data  out  DATA_W  registered write data; 0 if no write occurred.
- retire_cnt  out  64  count of accepted beats.

Behaviour:
- Reset (reset=0, asynchronous):
  - All 32 registers clear to 0.
  - commit_valid=0; commit_pc, commit_ins, commit_rd and commit_data clear to 0.
  - retire_cnt=0; wb_ready=0.
- wb_ready
  - Registered; becomes 1 on the first rising edge after reset deasserts, then stays 1.
  - No back-pressure after that.
- Accept
  - A beat is accepted when wb_valid & wb_ready are both high at the rising edge.
  - Inputs are sampled only on an accepted beat; otherwise they are don't-care.
- Register write
  - On accept with wb_we=1 and wb_rd!=0: reg[wb_rd] <= wb_data.
  - wb_rd=0: no write; x0 always reads 0.
  - wb_we=0: no write, but the beat still retires.
- Commit record, latency 1 cycle
  - On accept: commit_valid<=1; commit_pc<=wb_pc; commit_ins<=wb_ins.
  - commit_rd and commit_data take wb_rd and wb_data when a write occurs, else 0.
  - No accept in a cycle: commit_valid<=0; other commit fields hold their value.
- retire_cnt
  - Increments by 1 per accepted beat.
  - 64-bit, wraps from 2^64-1 to 0 with no flag.
- Read ports
  - Combinational from the array.
  - Address 0 returns 0.
  - Both ports may read the same register.
- Simultaneous read and write to the same register:
  - Without the optional feature: the read returns the old value, and the new value is visible the cycle after.
- Reset mid-operation
  - A beat present when reset asserts is dropped: not written, not counted, no commit pulse.
  - After release, the first beat can be accepted one cycle later, once wb_ready=1.

Optional Feature:
- Macro: YSYX_22041071_RF_BYPASS_EN.
- Defined: each read port compares its address with wb_rd during an accepting write beat (wb_valid&wb_ready&wb_we&wb_rd!=0). On a match, the read port returns wb_data combinationally (write-to-read forwarding).
- Undefined: no forwarding; read ports return the array value only.

Test Plan:
- Reset, then release -> all registers read 0, retire_cnt=0, commit_valid=0; wb_ready=0 in the release cycle and 1 from the next edge.
- Accept beat pc=0x80000000, ins=0x00100093, we=1, rd=1, data=0x1 -> next cycle:
  - rs1_addr=1 reads 0x1.
  - commit_valid=1 for exactly one cycle with pc=0x80000000, rd=1, data=0x1.
  - retire_cnt=1.
- Beat with we=1, rd=0, data=0xDEADBEEF -> x0 still reads 0; commit_rd=0, commit_data=0; retire_cnt increments.
- Beat with we=1, rd=5, data=0xA5A5, while rs1_addr=rs2_addr=5 in the same cycle:
  - Bypass undefined: both ports read the old value 0 in that cycle, and 0xA5A5 the next cycle.
  - Bypass defined: both ports read 0xA5A5 in that cycle.
- 10 back-to-back beats with wb_valid=1, then wb_valid=0 for 3 cycles -> retire_cnt=10; commit_valid high for 10 consecutive cycles then low; commit_pc holds the last PC.
- Assert reset while wb_valid=1, we=1, rd=3, data=0x77 -> x3=0, retire_cnt=0, no commit pulse; normal acceptance resumes one cycle after release.
